// File: rtl/zynet_cfg_seq_pkg.sv
// Shared definitions for the ZyNet configuration sequencer.
// Holds the register offsets, the per-layer neuron and weight tables, the FSM state
// encoding and a small helper that reads one entry from a packed table.
package zynet_cfg_seq_pkg;

  // Register offsets in the target accelerator
  localparam logic [31:0] REG_WEIGHT = 32'd0;
  localparam logic [31:0] REG_BIAS   = 32'd4;
  localparam logic [31:0] REG_LAYER  = 32'd12;
  localparam logic [31:0] REG_NEURON = 32'd16;
  localparam logic [31:0] REG_SRST   = 32'd28;

  localparam int unsigned MAX_LAYERS = 4;
  localparam int unsigned TBL_W      = 16;

  // Entry 0 is layer 1; entries are TBL_W bits wide
  typedef logic [MAX_LAYERS*TBL_W-1:0] tbl_t;

  localparam tbl_t NEURONS_TBL = {16'd10, 16'd10, 16'd30, 16'd30};
  localparam tbl_t WEIGHTS_TBL = {16'd10, 16'd30, 16'd30, 16'd784};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SRST   = 3'd1,
    ST_LAYER  = 3'd2,
    ST_NEURON = 3'd3,
    ST_FETCH  = 3'd4,
    ST_DATA   = 3'd5,
    ST_WRESP  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  // Index is the zero-based layer; callers keep it below MAX_LAYERS
  function automatic logic [TBL_W-1:0] tbl_get(input tbl_t tbl, input logic [TBL_W-1:0] idx);
    return tbl[int'(idx)*TBL_W +: TBL_W];
  endfunction

endpackage

// File: rtl/zynet_cfg_seq_if.sv
// AXI4-lite write channel bundle used between the sequencer and its target.
// master: drives AW/W, accepts B.  slave: the opposite direction.
interface zynet_cfg_seq_if;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );
endinterface

// File: rtl/zynet_cfg_seq_axil_wr_single.sv
// Single outstanding AXI-lite write.
// Ports: clk, rst_n (async active-low); req holds addr/data stable while the address
// and data phases run; sent pulses when both AW and W have been accepted; then bready
// is raised and ack pulses on the B handshake, with resp_err flagging a non-OKAY bresp.
// axi: master side of the write bundle.
module axil_wr_single (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic [31:0]             addr,
  input  logic [31:0]             data,
  output logic                    sent,
  output logic                    ack,
  output logic                    resp_err,
  zynet_cfg_seq_if.master         axi
);

  logic aw_done_q, w_done_q, resp_q;
  logic aw_ok, w_ok;

  always_comb begin
    // Each valid drops on its own ready and stays low until the write completes
    axi.m_axi_awvalid = req & ~aw_done_q;
    axi.m_axi_wvalid  = req & ~w_done_q;
    axi.m_axi_awaddr  = addr;
    axi.m_axi_wdata   = data;
    axi.m_axi_wstrb   = 4'hF;
    axi.m_axi_bready  = resp_q;
    aw_ok             = aw_done_q | axi.m_axi_awready;
    w_ok              = w_done_q | axi.m_axi_wready;
    sent              = req & aw_ok & w_ok;
    ack               = resp_q & axi.m_axi_bvalid;
    resp_err          = ack & (axi.m_axi_bresp != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      if (sent) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (axi.m_axi_awvalid && axi.m_axi_awready) aw_done_q <= 1'b1;
        if (axi.m_axi_wvalid && axi.m_axi_wready) w_done_q <= 1'b1;
      end
      if (sent) begin
        resp_q <= 1'b1;
      end else if (ack) begin
        resp_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/zynet_cfg_seq.sv
// ZyNet configuration sequencer.
// On start, clears the accelerator soft reset, then walks every layer/neuron writing
// all weights (weight phase) and then one bias per neuron (bias phase), pulling the
// data words sequentially from config memory. Aborts on a non-OKAY write response.
// Ports: s_axi_aclk, s_axi_aresetn (async active-low); start; busy, done (pulse), err
// (sticky); mem_rd_en/mem_addr/mem_rdata config-memory read port (1-cycle latency);
// axi: AXI-lite write master bundle.
module zynet_cfg_seq
  import zynet_cfg_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned MEM_AW     = 15,
  parameter tbl_t        NEURONS    = NEURONS_TBL,
  parameter tbl_t        WEIGHTS    = WEIGHTS_TBL
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  zynet_cfg_seq_if.master   axi
);

  state_e            state_q, state_d;
  state_e            last_q, last_d;     // which write is awaiting its response
  logic              phase_q, phase_d;   // 0: weights, 1: biases
  logic [15:0]       layer_q, layer_d;   // zero-based layer index
  logic [15:0]       neuron_q, neuron_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              first_q;            // first DATA cycle: memory output is live
  logic [31:0]       rdata_q;

  logic        wr_req, wr_sent, wr_ack, wr_err;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] cur_neurons, cur_weights;
  logic        last_layer, last_neuron, last_weight;

  always_comb begin
    cur_neurons = tbl_get(NEURONS, layer_q);
    cur_weights = tbl_get(WEIGHTS, layer_q);
    last_layer  = (layer_q == 16'(NUM_LAYERS - 1));
    last_neuron = (neuron_q == cur_neurons - 16'd1);
    last_weight = (wcnt_q == cur_weights - 16'd1);
  end

  assign wr_req = (state_q == ST_SRST) || (state_q == ST_LAYER) ||
                  (state_q == ST_NEURON) || (state_q == ST_DATA);

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      ST_SRST:   wr_addr = REG_SRST;
      ST_LAYER: begin
        wr_addr = REG_LAYER;
        wr_data = {16'h0, layer_q + 16'd1};
      end
      ST_NEURON: begin
        wr_addr = REG_NEURON;
        wr_data = {16'h0, neuron_q};
      end
      ST_DATA: begin
        wr_addr = phase_q ? REG_BIAS : REG_WEIGHT;
        // Memory data is only valid the cycle after the read; hold it afterwards
        wr_data = first_q ? mem_rdata : rdata_q;
      end
      default: ;
    endcase
  end

  axil_wr_single u_wr (
    .clk      (s_axi_aclk),
    .rst_n    (s_axi_aresetn),
    .req      (wr_req),
    .addr     (wr_addr),
    .data     (wr_data),
    .sent     (wr_sent),
    .ack      (wr_ack),
    .resp_err (wr_err),
    .axi      (axi)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    phase_d  = phase_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SRST;
          err_d    = 1'b0;
          phase_d  = 1'b0;
          layer_d  = '0;
          neuron_d = '0;
          wcnt_d   = '0;
          addr_d   = '0;
        end
      end
      ST_SRST, ST_LAYER, ST_NEURON, ST_DATA: begin
        if (wr_sent) begin
          last_d  = state_q;
          state_d = ST_WRESP;
        end
      end
      ST_FETCH: state_d = ST_DATA;
      ST_WRESP: begin
        if (wr_ack) begin
          if (wr_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            case (last_q)
              ST_SRST:   state_d = ST_LAYER;
              ST_LAYER:  state_d = ST_NEURON;
              ST_NEURON: state_d = ST_FETCH;
              default: begin
                addr_d = addr_q + MEM_AW'(1);
                if (!phase_q && !last_weight) begin
                  wcnt_d  = wcnt_q + 16'd1;
                  state_d = ST_FETCH;
                end else begin
                  wcnt_d = '0;
                  if (!last_neuron) begin
                    neuron_d = neuron_q + 16'd1;
                    state_d  = ST_NEURON;
                  end else begin
                    neuron_d = '0;
                    if (!last_layer) begin
                      layer_d = layer_q + 16'd1;
                      state_d = ST_LAYER;
                    end else begin
                      layer_d = '0;
                      if (!phase_q) begin
                        phase_d = 1'b1;
                        state_d = ST_LAYER;
                      end else begin
                        state_d = ST_DONE;
                      end
                    end
                  end
                end
              end
            endcase
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q  <= ST_IDLE;
      last_q   <= ST_IDLE;
      phase_q  <= 1'b0;
      layer_q  <= '0;
      neuron_q <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      phase_q  <= phase_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      first_q  <= (state_q == ST_FETCH);
      if (first_q) rdata_q <= mem_rdata;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign mem_rd_en = (state_q == ST_FETCH);
  assign mem_addr  = addr_q;

endmodule

// File: doc/zynet_cfg_seq.md
ZYNET_CFG_SEQ -- requirements
Module: zynet_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, the number of network layers to configure.
REQ-002 SHALL have parameter MEM_AW, default 15, the config-memory word-address width.
REQ-003 SHALL have port s_axi_aclk, input, 1: the single clock.
REQ-004 SHALL have port s_axi_aresetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a configuration run.
REQ-006 SHALL have ports busy (output, 1: run in progress) and done (output, 1: one-cycle end-of-run pulse).
REQ-007 SHALL have port err, output, 1: sticky; last run aborted on a non-OKAY bresp.
REQ-008 SHALL have ports mem_rd_en (output, 1) and mem_addr (output, MEM_AW) as the config-memory read request.
REQ-009 SHALL have port mem_rdata, input, 32: read data, valid exactly 1 cycle after mem_rd_en.
REQ-010 SHALL have AXI-lite write-master ports: m_axi_awaddr (output, 32), m_axi_awvalid (output, 1), m_axi_awready (input, 1).
REQ-011 SHALL have write-data ports m_axi_wdata (output, 32), m_axi_wstrb (output, 4, constant 4'hF), m_axi_wvalid (output, 1), m_axi_wready (input, 1).
REQ-012 SHALL have write-response ports m_axi_bresp (input, 2), m_axi_bvalid (input, 1), m_axi_bready (output, 1).

Function
REQ-013 SHALL sample start only in IDLE; start while busy SHALL be ignored.
REQ-014 SHALL write registers in this order: 28<=0 (clear soft reset); weight phase; bias phase; then DONE.
REQ-015 Weight phase SHALL do, per layer k=1..NUM_LAYERS: 12<=k; then per neuron j=0..NEURONS[k]-1: 16<=j, then WEIGHTS[k] writes to address 0.
REQ-016 Bias phase SHALL do, per layer k: 12<=k; then per neuron j: 16<=j, then one write to address 4.
REQ-017 Weight and bias data SHALL come from config memory at a word address that starts at 0 on each run and increments by 1 per data write; all biases follow the last weight.
REQ-018 Each data write SHALL be preceded by one FETCH cycle (mem_rd_en=1); mem_rdata SHALL be registered and then driven unmodified on wdata.
REQ-019 FSM states SHALL be IDLE, SRST, LAYER, NEURON, FETCH, DATA, WRESP, DONE; a phase flag SHALL select weight or bias.
REQ-020 Each write SHALL raise awvalid and wvalid together with stable awaddr/wdata; each valid drops independently on its own ready and neither re-asserts until WRESP completes.
REQ-021 bready SHALL be 1 in WRESP only; a write completes on bvalid&bready; at most one write SHALL be outstanding.
REQ-022 Minimum write cost SHALL be 2 cycles (address/data accept, response accept); awvalid SHALL rise the cycle after the start sample.
REQ-023 Non-zero bresp SHALL set err, abort to DONE, pulse done, and return to IDLE; err SHALL clear on the next accepted start.
REQ-024 Layer, neuron and weight counters SHALL wrap to 0 on their terminal counts, with no extra cycles.
REQ-025 busy SHALL be 1 from the cycle after start acceptance through the DONE cycle.

Reset
REQ-026 Asserting s_axi_aresetn SHALL, at any time including mid-write, force IDLE and clear all counters.
REQ-027 During reset, busy, done, err, mem_rd_en, awvalid, wvalid and bready SHALL all be 0; mem_addr, awaddr and wdata SHALL be 0.
REQ-028 Reset SHALL NOT wait for an outstanding AXI response.

Structure
REQ-029 A shared package SHALL hold the register offsets (WEIGHT=0, BIAS=4, LAYER=12, NEURON=16, SRST=28), the NEURONS table {30,30,10,10}, the WEIGHTS table {784,30,30,10}, and the FSM state enum.
REQ-030 One sub-module, axil_wr_single, SHALL implement the single-write AW/W/B handshake with inputs req/addr/data and outputs ack/resp_err.

Verification
REQ-031 Defaults, always-ready slave, start pulse -> 25069 writes total; first write 28<=0, last write 4<=mem[24899]; done pulses once; err=0.
REQ-032 Slave with awready delayed 3 cycles and wready 0 delay -> wvalid drops after 1 cycle, awvalid holds 3 cycles, with no duplicate write.
REQ-033 bresp=2'b10 on the 5th write -> err=1, done pulses, exactly 5 writes are issued, then IDLE.
REQ-034 start re-pulsed mid-run -> write count stays 25069; a second start after done -> a full second run with err cleared.
REQ-035 aresetn low during WRESP of the neuron write -> all outputs 0 next cycle; a new start restarts at 28<=0 with mem_addr 0.
REQ-036 Memory scoreboard -> every weight/bias wdata equals mem[addr] in ascending addr order, with 12/16 values matching k/j.
